// File: rtl/mem_responder.sv
// Valid/ready memory responder for the RV32 core's unified memory.
// It adds a configurable wait-state latency, byte-lane write strobes and alignment/range error reporting.
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int              CNT_W     = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int              IDX_W     = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [29:0]     DEPTH_W30 = 30'(DEPTH_WORDS);
    localparam logic [29:0]     BASE_WORD = BASE_ADDR[31:2];

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept, access;

    logic             lat_write;
    logic [31:0]      lat_addr, lat_wdata;
    logic [3:0]       lat_wstrb;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic [31:0]      merged;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = WAIT;
            end
            WAIT: if (cnt == '0) state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && req_valid;
    assign access = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset)                    cnt <= '0;
        else if (accept)              cnt <= CNT_INIT;
        else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end

    // Request fields are captured once; WAIT ignores the live inputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
        end
    end

    assign word_off = lat_addr[31:2] - BASE_WORD;
    assign idx      = word_off[IDX_W-1:0];
    assign acc_err  = (lat_addr[1:0] != 2'b00) || (lat_addr < BASE_ADDR) ||
                      (word_off >= DEPTH_W30);

    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < 4; i++)
            if (lat_wstrb[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
    end

    // Reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (access && !reset && lat_write && !acc_err) mem[idx] <= merged;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (access) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (!acc_err && !lat_write) ? mem[idx] : 32'h0;
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RV32 core's unified instruction/data memory. It turns the core's memory accesses into a valid/ready request–response transaction, with configurable wait states, byte-lane write strobes, and alignment/range error reporting. It sits between the core's memory port and a word-organised storage array, and replaces the zero-latency memory so the controller can be exercised against realistic memory latency.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array.
- WAIT_CYCLES, 2: added latency per access, range 0–15.
- BASE_ADDR, 32'h00000000: byte address of word 0. Must be word-aligned.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data, lane i = bits [8i+7:8i].
- req_wstrb  in  4  byte-lane write enables; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  access was misaligned or out of range.
- busy  out  1  a transaction is in progress (state ≠ IDLE).

## Operation
FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready = 1.
  - On the edge where req_valid && req_ready, latch req_write, req_addr, req_wdata and req_wstrb into internal registers.
  - Load wait counter = WAIT_CYCLES. Go to WAIT.
- **WAIT**
  - req_ready = 0.
  - Each edge: if counter == 0, perform the access and go to RESP; otherwise decrement the counter.
  - Request inputs are ignored in this state; only the latched copies are used.
- **Access** (the edge that leaves WAIT):
  - word index = (addr − BASE_ADDR) >> 2.
  - err = (addr[1:0] ≠ 0) || (addr < BASE_ADDR) || (index ≥ DEPTH_WORDS).
  - Write, no error: each lane i with wstrb[i] = 1 takes wdata lane i; other lanes keep their value. wstrb = 0 is a legal no-op that completes with err = 0.
  - Read, no error: rsp_rdata is registered from array[index].
  - Error: the array is not modified and rsp_rdata = 0.
- **RESP**
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until the handshake.
  - On the edge where rsp_valid && rsp_ready, go to IDLE.
  - A new request cannot be accepted on the same edge as the response handshake.
- Reads return the merged post-write contents of any earlier completed write; there is no bypass or reordering.
- Array contents are not reset. At simulation start they are initialised to 0.
- Counter width = max(1, $clog2(WAIT_CYCLES+1)).

## Timing
- **Reset**
  - On the reset edge, state → IDLE.
  - Output values after that edge: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - Reset overrides every other event on the same edge.
- **Latency**, for a request accepted at edge k:
  - Access and commit occur at edge k+WAIT_CYCLES+1.
  - rsp_valid is high from that edge onward.
  - With WAIT_CYCLES = 0, rsp_valid rises one edge after acceptance.
- **Throughput**: minimum is one transaction per WAIT_CYCLES+3 cycles (accept, waits, response, re-accept).
- **Backpressure**: while rsp_ready = 0, the FSM stays in RESP indefinitely with outputs frozen and req_ready = 0.
- **Reset during WAIT**
  - The pending write is discarded and the array is unchanged.
  - If reset coincides with the commit edge, reset wins and no write occurs.
- **Reset during RESP**: the response is dropped and rsp_valid = 0 after the edge.
- req_ready and busy are pure decodes of the state register. rsp_* are driven from registers only; there is no combinational path from input to output.

## Test plan
- **Latency:** WAIT_CYCLES = 2. Write 0xDEADBEEF to 0x10 with wstrb 4'b1111, accepted at edge k.
  - Required: rsp_valid at edge k+3 with err = 0 and rdata = 0.
  - Then read 0x10 → rdata = 0xDEADBEEF, err = 0.
- **Byte strobes:** over 0xDEADBEEF, write 0x11223344 with wstrb 4'b0101; then read 0x10 → 0xDE22BE44. A write with wstrb = 0 leaves the word unchanged and returns err = 0.
- **Errors:**
  - Write to 0x13 → err = 1, rdata = 0, and 0x10 still reads 0xDE22BE44.
  - Read of BASE_ADDR + 4*DEPTH_WORDS → err = 1, rdata = 0.
- **Backpressure:** hold rsp_ready = 0 for 5 cycles after rsp_valid rises, with req_valid = 1 throughout.
  - Required: rsp_valid, rdata and err stay stable; req_ready = 0; busy = 1.
  - The second request is accepted only at handshake edge + 1.
- **Reset in WAIT:** assert reset for one cycle during WAIT of a write of 0xCAFEF00D to 0x20 (previously 0).
  - Required: outputs at their reset values; a subsequent read of 0x20 → 0x00000000.
  - Repeat with reset exactly on the commit edge and require the same result.
- **WAIT_CYCLES = 0 back-to-back:** rsp_ready tied to 1, 4 consecutive reads.
  - Required: each rsp_valid exactly one edge after its accept, and an accept every 3 cycles.
